// File: rtl/axi_wr_arbiter.sv
// Two-master AXI write arbiter in front of a single SRAM-bridge write port.
// Round-robin grant from AW requests, one transaction in flight, per-master write counters.
module axi_wr_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int STRB_W = 8,
    parameter int ID_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2*ID_W-1:0]   m_awid,
    input  logic [2*ADDR_W-1:0] m_awaddr,
    input  logic [5:0]          m_awsize,
    input  logic [1:0]          m_awvalid,
    output logic [1:0]          m_awready,
    input  logic [2*DATA_W-1:0] m_wdata,
    input  logic [2*STRB_W-1:0] m_wstrb,
    input  logic [1:0]          m_wlast,
    input  logic [1:0]          m_wvalid,
    output logic [1:0]          m_wready,
    output logic [2*ID_W-1:0]   m_bid,
    output logic [3:0]          m_bresp,
    output logic [1:0]          m_bvalid,
    input  logic [1:0]          m_bready,
    output logic [ID_W-1:0]     s_awid,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [2:0]          s_awsize,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [STRB_W-1:0]   s_wstrb,
    output logic                s_wlast,
    output logic                s_wvalid,
    input  logic                s_wready,
    input  logic [ID_W-1:0]     s_bid,
    input  logic [1:0]          s_bresp,
    input  logic                s_bvalid,
    output logic                s_bready,
    output logic                grant,
    output logic                busy,
    output logic [15:0]         txn_cnt0,
    output logic [15:0]         txn_cnt1
);
    // Handshakes: a beat moves on the rising edge where valid and ready are both 1; a valid
    // stays up with stable payload until that edge, and no ready here depends on its own valid.
    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, RESP = 2'd2} state_t;

    state_t state, state_next;
    logic   grant_next, rr_last, rr_last_next;
    logic   aw_done, aw_done_next, w_done, w_done_next;
    logic   inc0, inc1, aw_hs, w_hs, b_hs;

    logic [ID_W-1:0]   g_awid;
    logic [ADDR_W-1:0] g_awaddr;
    logic [2:0]        g_awsize;
    logic [DATA_W-1:0] g_wdata;
    logic [STRB_W-1:0] g_wstrb;
    logic              g_awvalid, g_wvalid, g_wlast, g_bready;

    assign g_awid    = grant ? m_awid[ID_W +: ID_W]       : m_awid[0 +: ID_W];
    assign g_awaddr  = grant ? m_awaddr[ADDR_W +: ADDR_W] : m_awaddr[0 +: ADDR_W];
    assign g_awsize  = grant ? m_awsize[5:3]              : m_awsize[2:0];
    assign g_wdata   = grant ? m_wdata[DATA_W +: DATA_W]  : m_wdata[0 +: DATA_W];
    assign g_wstrb   = grant ? m_wstrb[STRB_W +: STRB_W]  : m_wstrb[0 +: STRB_W];
    assign g_awvalid = m_awvalid[grant];
    assign g_wvalid  = m_wvalid[grant];
    assign g_wlast   = m_wlast[grant];
    assign g_bready  = m_bready[grant];

    assign aw_hs = (state == XFER) & g_awvalid & ~aw_done & s_awready;
    assign w_hs  = (state == XFER) & g_wvalid & ~w_done & s_wready & g_wlast;
    assign b_hs  = (state == RESP) & s_bvalid & g_bready;
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= 1'b0;
            rr_last  <= 1'b1;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            txn_cnt0 <= 16'd0;
            txn_cnt1 <= 16'd0;
        end else begin
            state   <= state_next;
            grant   <= grant_next;
            rr_last <= rr_last_next;
            aw_done <= aw_done_next;
            w_done  <= w_done_next;
            if (inc0) txn_cnt0 <= txn_cnt0 + 16'd1;
            if (inc1) txn_cnt1 <= txn_cnt1 + 16'd1;
        end
    end

    always_comb begin
        state_next   = state;
        grant_next   = grant;
        rr_last_next = rr_last;
        aw_done_next = aw_done;
        w_done_next  = w_done;
        inc0         = 1'b0;
        inc1         = 1'b0;
        case (state)
            IDLE: begin
                // Only AW requests compete; a tie goes to whoever was not served last.
                if (|m_awvalid) begin
                    grant_next = (&m_awvalid) ? ~rr_last : m_awvalid[1];
                    state_next = XFER;
                end
            end
            XFER: begin
                aw_done_next = aw_done | aw_hs;
                w_done_next  = w_done | w_hs;
                if (aw_done_next && w_done_next) state_next = RESP;
            end
            RESP: begin
                if (b_hs) begin
                    inc0         = ~grant;
                    inc1         = grant;
                    rr_last_next = grant;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        m_bid     = '0;
        m_bresp   = '0;
        s_awid    = '0;
        s_awaddr  = '0;
        s_awsize  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wlast   = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        if (state == XFER) begin
            s_awid           = g_awid;
            s_awaddr         = g_awaddr;
            s_awsize         = g_awsize;
            s_awvalid        = g_awvalid & ~aw_done;
            m_awready[grant] = s_awready & ~aw_done;
            s_wdata          = g_wdata;
            s_wstrb          = g_wstrb;
            s_wlast          = g_wlast;
            s_wvalid         = g_wvalid & ~w_done;
            m_wready[grant]  = s_wready & ~w_done;
        end
        if (state == RESP) begin
            m_bvalid[grant] = s_bvalid;
            s_bready        = g_bready;
            if (grant) begin
                m_bid[ID_W +: ID_W] = s_bid;
                m_bresp[3:2]        = s_bresp;
            end else begin
                m_bid[0 +: ID_W] = s_bid;
                m_bresp[1:0]     = s_bresp;
            end
        end
    end
endmodule

// File: doc/axi_wr_arbiter.md
Name: axi_wr_arbiter

Overview:
- Two-master AXI write-channel arbiter in front of the single write port of the AXI-to-SRAM bridge.
- Lets the CPU-side master (M0) and a second requester (M1, DMA/test master) share the SRAM write path.
- Round-robin arbitration; one write transaction in flight at a time.
- Routes AW, W and B for the granted master only; counts completed writes per master.

Parameters:
ADDR_W, 32, AW address width
DATA_W, 64, W data width
STRB_W, 8, wstrb width (DATA_W/8)
ID_W, 4, awid/bid width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
m_awid  in  2*ID_W  per-master AW id, master i at bits [i*ID_W +: ID_W]
m_awaddr  in  2*ADDR_W  per-master AW address
m_awsize  in  2*3  per-master AW size
m_awvalid  in  2  per-master AW valid
m_awready  out  2  per-master AW ready
m_wdata  in  2*DATA_W  per-master W data
m_wstrb  in  2*STRB_W  per-master W strobes
m_wlast  in  2  per-master W last
m_wvalid  in  2  per-master W valid
m_wready  out  2  per-master W ready
m_bid  out  2*ID_W  per-master B id
m_bresp  out  2*2  per-master B response
m_bvalid  out  2  per-master B valid
m_bready  in  2  per-master B ready
s_awid, s_awaddr, s_awsize, s_awvalid  out  ID_W/ADDR_W/3/1  AW channel to bridge
s_awready  in  1  bridge AW ready
s_wdata, s_wstrb, s_wlast, s_wvalid  out  DATA_W/STRB_W/1/1  W channel to bridge
s_wready  in  1  bridge W ready
s_bid, s_bresp, s_bvalid  in  ID_W/2/1  B channel from bridge
s_bready  out  1  B ready to bridge
grant  out  1  index of the granted master (valid when busy=1)
busy  out  1  1 while in XFER or RESP
txn_cnt0, txn_cnt1  out  16 each  completed-write counters, M0/M1

Behaviour:
- Reset (async, immediate): state=IDLE; grant=0; rr_last=1 (M0 wins first tie); aw_done=w_done=0; txn_cnt0=txn_cnt1=0; all m_*ready, m_bvalid, s_awvalid, s_wvalid, s_bready=0; data/id outputs 0.
- FSM states: IDLE, XFER, RESP.
- IDLE: arbitration uses only m_awvalid; W-only requests are ignored.
  - One master requesting: that master is granted.
  - Both requesting: grant = ~rr_last.
  - Grant registered at edge N; state=XFER from N+1. One cycle of latency; no combinational valid-to-ready path in IDLE.
- XFER, granted master g:
  - AW: s_aw* = m_aw*[g]; s_awvalid = m_awvalid[g] & ~aw_done; m_awready[g] = s_awready & ~aw_done.
  - W: s_w* = m_w*[g]; s_wvalid = m_wvalid[g] & ~w_done; m_wready[g] = s_wready & ~w_done.
  - aw_done sets on the AW handshake. w_done sets on a W handshake with wlast=1. Multi-beat bursts pass through unchanged.
  - AW and W are independent: W may complete before, with, or after AW.
  - Go to RESP on the edge where both done flags are (or become) set, including both completing in the same cycle.
- RESP:
  - m_bvalid[g] = s_bvalid; m_bid/m_bresp[g] = s_bid/s_bresp; s_bready = m_bready[g].
  - On the B handshake: txn_cnt[g]+1 (wraps 0xFFFF->0); rr_last=g; clear done flags; return to IDLE.
  - The next grant appears no earlier than the cycle after that IDLE cycle.
- Non-granted master: awready, wready, bvalid all 0 at all times.
- In IDLE, s_*valid and s_bready are 0.
- s_bvalid outside RESP is ignored (s_bready=0).
- A master that drops awvalid before its handshake stalls XFER; it is not aborted.
- All channel outputs in XFER/RESP are combinational from inputs and registered state.

Test Plan:
- M0 only: awaddr=0x4, awsize=2, wdata=0xabcdaaaa12345678, wstrb=0xff, wlast=1, bready=1 -> s_awaddr=0x4 from the cycle after request; one B to M0; txn_cnt0=1; busy returns to 0.
- Both masters request in the same cycle (M0 0x4, M1 0x100 with wdata 0xaaaabbbbccccdddd) -> M0 served first, then M1; bridge sees 0x4 then 0x100; txn_cnt0=1, txn_cnt1=1.
- M1 holds its request over 3 back-to-back M0 writes -> grants alternate M0, M1, M0, M1; M1 is never starved.
- W before AW: M0 wvalid asserted 3 cycles before awvalid, s_awready held 0 -> w_done sets first; RESP entered only after the AW handshake; exactly one B.
- 4-beat burst with s_wready toggling -> all 4 beats forwarded in order; wlast only on beat 4; m_wready tracks s_wready.
- Assert reset in RESP with s_bvalid=1 -> all valids/readies 0 immediately; counters 0; next request is granted normally.
